// File: rtl/exec_ctrl_if.sv
// Handshake bundle between decode, execute control and memory stage.
// Decode/memory side is master, execute control is slave.
interface exec_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE_q;
  logic        cnd_q;

  modport master (
    output in_valid,
    output icode,
    output ifun,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  valE_q,
    input  cnd_q
  );

  modport slave (
    input  in_valid,
    input  icode,
    input  ifun,
    input  out_ready,
    output in_ready,
    output out_valid,
    output valE_q,
    output cnd_q
  );
endinterface

// File: rtl/exec_ctrl.sv
// Execute-stage controller: ALU operand/op select, condition codes,
// condition evaluation and result hand-off to the memory stage.
module exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  exec_ctrl_if.slave  bus,
  input  logic [63:0] alu_result,
  input  logic        alu_ovf,
  output logic [1:0]  alu_op,
  output logic [1:0]  sel_a,
  output logic        sel_b,
  output logic [2:0]  cc,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  icode_q;
  logic [3:0]  ifun_q;
  logic [63:0] vale_r;
  logic        cnd_r;
  logic        accept;
  logic        halt_op;
  logic        bad_op;
  logic        cnd;
  logic        cnd_bad;
  logic        zf;
  logic        sf;
  logic        of;
  logic        lt;
  logic [1:0]  sel_a_d;
  logic        sel_b_d;
  logic [1:0]  alu_op_d;

  assign {zf, sf, of} = cc;
  assign lt = sf ^ of;

  assign bus.in_ready  = (state == IDLE) ||
                         ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.valE_q    = vale_r;
  assign bus.cnd_q     = cnd_r;

  assign accept  = bus.in_valid && bus.in_ready;
  assign halt_op = (bus.icode == 4'h0);
  assign bad_op  = (bus.icode > 4'hB);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: halt/invalid go straight to STOP, skipping execute
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (halt_op || bad_op) ? STOP : EXEC;
      end
      EXEC: state_nx = DONE;
      DONE: begin
        if (accept)
          state_nx = (halt_op || bad_op) ? STOP : EXEC;
        else if (bus.out_ready)
          state_nx = IDLE;
      end
      STOP: state_nx = STOP;
    endcase
  end

  // Operand/op decode for the incoming instruction
  always_comb begin
    sel_a_d  = 2'b10;
    sel_b_d  = 1'b0;
    alu_op_d = 2'b00;
    unique case (1'b1)
      bus.icode inside {4'h2, 4'h6}:       sel_a_d = 2'b00;
      bus.icode inside {4'h3, 4'h4, 4'h5}: sel_a_d = 2'b01;
      default: ;
    endcase
    sel_b_d = bus.icode inside
      {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    unique case (1'b1)
      bus.icode == 4'h6:             alu_op_d = bus.ifun[1:0];
      bus.icode inside {4'h8, 4'hA}: alu_op_d = 2'b01;
      default: ;
    endcase
  end

  // Condition from pre-update flags; only cmov/jXX are conditional
  always_comb begin
    cnd     = 1'b1;
    cnd_bad = 1'b0;
    if ((icode_q == 4'h2) || (icode_q == 4'h7)) begin
      unique case (ifun_q)
        4'h0: cnd = 1'b1;
        4'h1: cnd = lt | zf;
        4'h2: cnd = lt;
        4'h3: cnd = zf;
        4'h4: cnd = ~zf;
        4'h5: cnd = ~lt;
        4'h6: cnd = ~(lt | zf);
        default: begin
          cnd     = 1'b0;
          cnd_bad = 1'b1;
        end
      endcase
    end
  end

  // Capture on accept, result/flags on the EXEC->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      sel_a   <= 2'b00;
      sel_b   <= 1'b0;
      alu_op  <= 2'b00;
      vale_r  <= 64'd0;
      cnd_r   <= 1'b0;
      cc      <= 3'b100;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        icode_q <= bus.icode;
        ifun_q  <= bus.ifun;
        if (halt_op) halted <= 1'b1;
        if (bad_op)  err    <= 1'b1;
        if (!(halt_op || bad_op)) begin
          sel_a  <= sel_a_d;
          sel_b  <= sel_b_d;
          alu_op <= alu_op_d;
        end
      end
      if (state == EXEC) begin
        vale_r <= alu_result;
        cnd_r  <= cnd;
        if (cnd_bad) err <= 1'b1;
        if (icode_q == 4'h6)
          cc <= {(alu_result == 64'd0), alu_result[63], alu_ovf};
      end
    end
  end

endmodule
